// File: rtl/rr_arb_4.sv
// Four-way round-robin arbiter with a bounded grant length.
// After every grant, gnt returns to zero for at least one cycle before the next grant.
module rr_arb_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic       busy_nxt, timeout_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic       found;
  logic [1:0] pick_idx;
  logic       rel_normal, rel_limit;

  // Search order starts just after the last grantee, so the last grantee is checked last.
  always_comb begin
    logic [1:0] idx;
    found    = 1'b0;
    pick_idx = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign rel_normal = done | ~req[ptr];
  assign rel_limit  = (cnt == LIMIT);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = 4'(1) << pick_idx;
          busy_nxt  = 1'b1;
          ptr_nxt   = pick_idx;
          cnt_nxt   = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 8'd1;
        if (rel_normal || rel_limit) begin
          gnt_nxt     = 4'b0000;
          busy_nxt    = 1'b0;
          // A normal release wins over the limit when both happen on the same edge.
          timeout_nxt = rel_limit & ~rel_normal;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= 8'd0;
      ptr     <= 2'd3;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed bench for rr_arb_4: the driver queues hand-computed outputs per edge,
// and a negedge monitor pops and compares them, also checking one-hot and busy on every cycle.
module tb_rr_arb_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;
    string      name;
  } exp_t;

  exp_t q[$];

  rr_arb_4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got gnt/busy/timeout=%b expected %b", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                      input logic et, input string name);
    exp_t e;
    req  = r;
    done = d;
    @(posedge clk);
    e.gnt = eg; e.busy = |eg; e.timeout = et; e.name = name;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if ($countones(gnt) > 1 || busy !== (|gnt)) begin
          failures++;
          $display("FAIL onehot_busy: got gnt=%b busy=%b expected one-hot gnt with busy=|gnt", gnt, busy);
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, {gnt, busy, timeout}, {e.gnt, e.busy, e.timeout});
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    #2;
    chk("reset_state", {gnt, busy, timeout}, 6'b0000_0_0);
    @(negedge clk);
    rst = 1'b0;

    // First grant after reset goes to requester 0; then a full rotation.
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "first_grant");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_rel0");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "rot_g1");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_rel1");
    step(4'b1111, 1'b0, 4'b0100, 1'b0, "rot_g2");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_rel2");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "rot_g3");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_rel3");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rot_wrap");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rot_relw");

    // done in IDLE is ignored; no preemption while granted.
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_done");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "nopre_g1");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "nopre_hold");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "nopre_rel");

    // Hold limit: four cycles, then forced release with a timeout pulse, then regrant.
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_c1");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_c2");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_c3");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_c4");
    step(4'b0010, 1'b0, 4'b0000, 1'b1, "to_release");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "to_regrant");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_reqdrop");

    // done on the last allowed cycle is a normal release.
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_done_c1");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_done_c2");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_done_c3");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_done_c4");
    step(4'b0010, 1'b1, 4'b0000, 1'b0, "lim_done_rel");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "lim_done_after");

    // Request drop on the last allowed cycle is also a normal release.
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_drop_c1");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_drop_c2");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_drop_c3");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "lim_drop_c4");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "lim_drop_rel");

    // Request drop mid-grant.
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "drop_g2");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_rel");

    // Asynchronous reset mid-grant, then the pointer restarts at requester 0.
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "rst_g3");
    req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {gnt, busy, timeout}, 6'b0000_0_0);
    @(posedge clk);
    #1;
    chk("rst_held", {gnt, busy, timeout}, 6'b0000_0_0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst_g0");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "post_rst_rel");

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
